hex_display_sequencer: RTL and testbench
========================================

Name: hex_display_sequencer

Overview:
- Bus-master sequencer that refreshes the six seven-segment digit registers of the GPIO peripheral from a single 24-bit hex value.
- On `start` it latches the value, then requests the shared peripheral bus and issues six single-cycle writes, digit 0 first.
- Each write goes to one digit register (byte offsets 0x00C, 0x010, ... 0x020) and carries the 7-segment encoding of one nibble.
- Sits beside the CPU data port on the peripheral bus; an external arbiter owns `bus_gnt`.

Parameters:
- ADDR_W, 12: peripheral address width.
- HEX_BASE, 12'h00C: address of digit 0 register.
- ADDR_STRIDE, 4: byte step between digit registers.
- NUM_DIGITS, 6: digits written per update (fixed at 6 for this design).
- ACTIVE_LOW, 1: 1 = segments driven low-on (bit=0 lights segment); 0 = high-on.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- start  in  1  one-cycle update request
- value  in  24  nibble i → digit i
- blank_mask  in  6  bit i set → digit i written all-segments-off
- busy  out  1  update in progress
- done  out  1  one-cycle pulse, update complete
- bus_req  out  1  bus request to arbiter
- bus_gnt  in  1  bus grant, may change any cycle
- CS  out  1  peripheral chip select
- WEN  out  1  write enable
- REN  out  1  read enable, tied 0
- Addr  out  ADDR_W  write address
- DataOut  out  32  write data, bits[31:7]=0

Behaviour:
- Decided: clock clk; reset rst, synchronous, active-high.
- Reset: state=IDLE, idx=0, busy=0, done=0, bus_req=0, CS=0, WEN=0, REN=0, Addr=0, DataOut=0, latched value/mask=0.
- States:
  - IDLE: busy=0. `start`=1 at edge → latch value and blank_mask, idx=0, go XFER.
  - XFER: busy=1, bus_req=1.
    - CS=WEN=bus_gnt (combinational from state and grant).
    - Addr = HEX_BASE + ADDR_STRIDE*idx.
    - DataOut = {25'b0, seg(idx)}.
    - Edge with bus_gnt=1: write counted; idx+1. If idx was 5, go FIN.
    - Edge with bus_gnt=0: stall. Hold idx, no CS, keep bus_req.
  - FIN: done=1 for exactly this cycle, busy=0, bus_req=0, CS=0 → IDLE next edge.
- CS/WEN/Addr/DataOut are 0 in IDLE and FIN.
- Latency: start sampled at edge k; with grant held high, writes occur in cycles k+1..k+6 and done=1 in cycle k+7. Each gnt=0 cycle adds one.
- seg(idx) encoding:
  - Active-high table, bit0=a..bit6=g: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - ACTIVE_LOW=1 → bitwise invert within 7 bits.
  - Blanked digit → 7'h00 when high-on, 7'h7F when low-on.
- `start` while busy or in FIN: ignored, latched value unchanged.
- `start` in the same cycle as rst: reset wins.
- rst mid-XFER: all outputs take reset values in the next cycle. Partially written digits are not rolled back.
- `value` and `blank_mask` changes after capture have no effect on the running update.

Decomposition:
- Package hex_disp_pkg:
  - state enum {IDLE, XFER, FIN}.
  - HEX_BASE/ADDR_STRIDE defaults.
  - 16-entry active-high segment table constant.
  - BLANK constant.
- Sub-module hex_to_7seg: 4-bit nibble + blank + ACTIVE_LOW param → 7-bit pattern, purely combinational. Instantiated once, fed by a nibble mux on idx.

Test Plan:
- Basic update: rst, then start with value=24'h123456, mask=0, bus_gnt tied 1 (ACTIVE_LOW=1).
  - Six writes in consecutive cycles, (Addr, DataOut): (00C,02) (010,12) (014,19) (018,30) (01C,24) (020,79).
  - done pulses once, one cycle after the last write; REN=0 throughout.
- Grant stalls: value=24'hF08000, mask=6'b100000, bus_gnt low for 3 cycles after start and low again before digit 3.
  - Writes in order: 40, 40, 40, 00, 40, 7F.
  - No CS while gnt=0; done arrives 4 cycles later than the ungated case.
- Busy-start: second start (value=24'hFFFFFF) issued mid-update.
  - Ignored; the data written remains from the first value.
  - Exactly six writes, one done pulse.
- Mid-update reset: assert rst during digit-2 write.
  - Next cycle: CS=0, bus_req=0, busy=0.
  - Fresh start afterwards writes all six digits starting from Addr=00C.
- Polarity: ACTIVE_LOW=0, value=24'h000008 → digit0 DataOut=0x7F, digits1–5=0x3F.
- Back-to-back: start asserted in the FIN cycle is ignored; start in the following IDLE cycle is accepted, and its first write occurs the cycle after.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display sequencer: FSM states,
// default digit register map and the seven-segment glyph table.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int          ADDR_W_DEFAULT      = 12;
  localparam logic [11:0] HEX_BASE_DEFAULT    = 12'h00C;
  localparam int          ADDR_STRIDE_DEFAULT = 4;
  localparam int          DIGIT_COUNT         = 6;
  localparam int          IDX_W               = 3;

  // Glyphs in active-high form, bit0 = segment a through bit6 = segment g.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] BLANK = 7'h00;

  function automatic logic [6:0] seg_active_high(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to seven-segment converter with blanking and
// selectable segment polarity.
module hex_to_7seg
  import hex_disp_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  // Blanking is applied before polarity so "all off" follows ACTIVE_LOW too.
  always_comb begin
    pattern = blank ? BLANK : seg_active_high(nibble);
    seg     = ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Bus-master sequencer that writes six seven-segment digit registers of the
// GPIO peripheral from a latched 24-bit hex value, one write per granted cycle.
module hex_display_sequencer
  import hex_disp_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] HEX_BASE    = ADDR_W'(HEX_BASE_DEFAULT),
  parameter int                ADDR_STRIDE = ADDR_STRIDE_DEFAULT,
  parameter int                NUM_DIGITS  = DIGIT_COUNT,
  parameter bit                ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       value,
  input  logic [5:0]        blank_mask,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              CS,
  output logic              WEN,
  output logic              REN,
  output logic [ADDR_W-1:0] Addr,
  output logic [31:0]       DataOut
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [23:0]      value_q;
  logic [5:0]       mask_q;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg;
  logic             in_xfer;

  // Single FSM: a write is only counted on an edge where the arbiter granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bus_req <= 1'b0;
      value_q <= '0;
      mask_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            value_q <= value;
            mask_q  <= blank_mask;
            idx     <= '0;
            busy    <= 1'b1;
            bus_req <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
          if (bus_gnt) begin
            if (idx == LAST_IDX) begin
              idx     <= '0;
              busy    <= 1'b0;
              bus_req <= 1'b0;
              done    <= 1'b1;
              state   <= FIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          idx     <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign nibble = value_q[{idx, 2'b00} +: 4];
  assign blank  = mask_q[idx];

  hex_to_7seg #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_hex_to_7seg (
    .nibble(nibble),
    .blank (blank),
    .seg   (seg)
  );

  // Bus strobes follow the grant directly so a stalled cycle never writes.
  assign in_xfer = (state == XFER);
  assign CS      = in_xfer & bus_gnt;
  assign WEN     = in_xfer & bus_gnt;
  assign REN     = 1'b0;
  assign Addr    = in_xfer ? HEX_BASE + ADDR_W'(ADDR_STRIDE * int'(idx)) : '0;
  assign DataOut = in_xfer ? {25'b0, seg} : '0;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer: vector table for the common flows
// plus hand-written sequences for reset, polarity and back-to-back corners.
module tb_hex_display_sequencer;
  timeunit 1ns;
  timeprecision 1ps;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] value = '0;
  logic [5:0]  blank_mask = '0;
  logic        bus_gnt = 1'b0;

  logic        busy, done, bus_req, CS, WEN, REN;
  logic [11:0] Addr;
  logic [31:0] DataOut;

  logic        hi_busy, hi_done, hi_bus_req, hi_CS, hi_WEN, hi_REN;
  logic [11:0] hi_Addr;
  logic [31:0] hi_DataOut;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hex_display_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .blank_mask(blank_mask),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .CS(CS), .WEN(WEN), .REN(REN), .Addr(Addr), .DataOut(DataOut)
  );

  hex_display_sequencer #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .start(start), .value(value), .blank_mask(blank_mask),
    .busy(hi_busy), .done(hi_done), .bus_req(hi_bus_req), .bus_gnt(bus_gnt),
    .CS(hi_CS), .WEN(hi_WEN), .REN(hi_REN), .Addr(hi_Addr), .DataOut(hi_DataOut)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        gnt;
    logic [23:0] value;
    logic [5:0]  mask;
    logic [49:0] expect_out;
  } vec_t;

  vec_t vectors[$];

  // Packed view: {busy, done, bus_req, CS, WEN, REN, Addr, DataOut}.
  function automatic logic [49:0] expOut(input logic b, input logic d, input logic r,
                                          input logic c, input logic [11:0] a,
                                          input logic [6:0] s);
    return {b, d, r, c, c, 1'b0, a, 25'b0, s};
  endfunction

  function automatic logic [49:0] observed();
    return {busy, done, bus_req, CS, WEN, REN, Addr, DataOut};
  endfunction

  function automatic vec_t mkRow(input string name, input logic r, input logic s,
                                 input logic g, input logic [23:0] v, input logic [5:0] m,
                                 input logic [49:0] e);
    vec_t row;
    row.name = name; row.rst = r; row.start = s; row.gnt = g;
    row.value = v; row.mask = m; row.expect_out = e;
    return row;
  endfunction

  // Inputs change on the falling edge; outputs are then read 1ns later.
  task automatic applyStimulus(input logic r, input logic s, input logic g,
                               input logic [23:0] v, input logic [5:0] m);
    @(negedge clk);
    rst = r; start = s; bus_gnt = g; value = v; blank_mask = m;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [49:0] actual,
                             input logic [49:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  logic [6:0]  exp123 [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0]  exp_pol_lo [6] = '{7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [6:0]  exp_pol_hi [6] = '{7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  initial begin
    logic [49:0] idle_exp;
    idle_exp = expOut(0, 0, 0, 0, 12'h000, 7'h00);

    // Basic update, grant held high.
    vectors.push_back(mkRow("basic idle", 0, 1, 1, 24'h123456, 6'h00, idle_exp));
    vectors.push_back(mkRow("basic d0",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h00C, 7'h02)));
    vectors.push_back(mkRow("basic d1",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h010, 7'h12)));
    vectors.push_back(mkRow("basic d2",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h014, 7'h19)));
    vectors.push_back(mkRow("basic d3",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h018, 7'h30)));
    vectors.push_back(mkRow("basic d4",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h01C, 7'h24)));
    vectors.push_back(mkRow("basic d5",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h020, 7'h79)));
    vectors.push_back(mkRow("basic done", 0, 0, 1, 24'h123456, 6'h00, expOut(0, 1, 0, 0, 12'h000, 7'h00)));
    vectors.push_back(mkRow("basic post", 0, 0, 1, 24'h123456, 6'h00, idle_exp));

    // Grant stalls: three low cycles up front, one more before digit 3.
    vectors.push_back(mkRow("stall idle", 0, 1, 1, 24'hF08000, 6'h20, idle_exp));
    vectors.push_back(mkRow("stall w0a",  0, 0, 0, 24'hF08000, 6'h20, expOut(1, 0, 1, 0, 12'h00C, 7'h40)));
    vectors.push_back(mkRow("stall w0b",  0, 0, 0, 24'hF08000, 6'h20, expOut(1, 0, 1, 0, 12'h00C, 7'h40)));
    vectors.push_back(mkRow("stall w0c",  0, 0, 0, 24'hF08000, 6'h20, expOut(1, 0, 1, 0, 12'h00C, 7'h40)));
    vectors.push_back(mkRow("stall d0",   0, 0, 1, 24'hF08000, 6'h20, expOut(1, 0, 1, 1, 12'h00C, 7'h40)));
    vectors.push_back(mkRow("stall d1",   0, 0, 1, 24'hF08000, 6'h20, expOut(1, 0, 1, 1, 12'h010, 7'h40)));
    vectors.push_back(mkRow("stall d2",   0, 0, 1, 24'hF08000, 6'h20, expOut(1, 0, 1, 1, 12'h014, 7'h40)));
    vectors.push_back(mkRow("stall w3",   0, 0, 0, 24'hF08000, 6'h20, expOut(1, 0, 1, 0, 12'h018, 7'h00)));
    vectors.push_back(mkRow("stall d3",   0, 0, 1, 24'hF08000, 6'h20, expOut(1, 0, 1, 1, 12'h018, 7'h00)));
    vectors.push_back(mkRow("stall d4",   0, 0, 1, 24'hF08000, 6'h20, expOut(1, 0, 1, 1, 12'h01C, 7'h40)));
    vectors.push_back(mkRow("stall d5",   0, 0, 1, 24'hF08000, 6'h20, expOut(1, 0, 1, 1, 12'h020, 7'h7F)));
    vectors.push_back(mkRow("stall done", 0, 0, 1, 24'hF08000, 6'h20, expOut(0, 1, 0, 0, 12'h000, 7'h00)));
    vectors.push_back(mkRow("stall post", 0, 0, 1, 24'hF08000, 6'h20, idle_exp));

    // Start while busy, with new value/mask driven for the rest of the update.
    vectors.push_back(mkRow("bs idle", 0, 1, 1, 24'h123456, 6'h00, idle_exp));
    vectors.push_back(mkRow("bs d0",   0, 0, 1, 24'h123456, 6'h00, expOut(1, 0, 1, 1, 12'h00C, 7'h02)));
    vectors.push_back(mkRow("bs d1",   0, 1, 1, 24'hFFFFFF, 6'h3F, expOut(1, 0, 1, 1, 12'h010, 7'h12)));
    vectors.push_back(mkRow("bs d2",   0, 0, 1, 24'hFFFFFF, 6'h3F, expOut(1, 0, 1, 1, 12'h014, 7'h19)));
    vectors.push_back(mkRow("bs d3",   0, 1, 1, 24'hFFFFFF, 6'h3F, expOut(1, 0, 1, 1, 12'h018, 7'h30)));
    vectors.push_back(mkRow("bs d4",   0, 0, 1, 24'hFFFFFF, 6'h3F, expOut(1, 0, 1, 1, 12'h01C, 7'h24)));
    vectors.push_back(mkRow("bs d5",   0, 0, 1, 24'hFFFFFF, 6'h3F, expOut(1, 0, 1, 1, 12'h020, 7'h79)));
    vectors.push_back(mkRow("bs done", 0, 0, 1, 24'hFFFFFF, 6'h3F, expOut(0, 1, 0, 0, 12'h000, 7'h00)));
    vectors.push_back(mkRow("bs post", 0, 0, 1, 24'hFFFFFF, 6'h3F, idle_exp));
    vectors.push_back(mkRow("bs post2", 0, 0, 1, 24'h000000, 6'h00, idle_exp));

    // Reset state.
    applyStimulus(1, 0, 1, 24'h0, 6'h0);
    applyStimulus(1, 1, 1, 24'h0, 6'h0);
    checkOutput("reset", observed(), idle_exp);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].rst, vectors[i].start, vectors[i].gnt,
                    vectors[i].value, vectors[i].mask);
      checkOutput(vectors[i].name, observed(), vectors[i].expect_out);
    end

    // start together with rst: reset wins.
    applyStimulus(1, 1, 1, 24'hFFFFFF, 6'h00);
    applyStimulus(0, 0, 1, 24'hFFFFFF, 6'h00);
    checkOutput("rst+start", observed(), idle_exp);
    applyStimulus(0, 0, 1, 24'hFFFFFF, 6'h00);
    checkOutput("rst+start idle", observed(), idle_exp);

    // Reset in the middle of digit 2.
    applyStimulus(0, 1, 1, 24'h123456, 6'h00);
    applyStimulus(0, 0, 1, 24'h123456, 6'h00);
    applyStimulus(0, 0, 1, 24'h123456, 6'h00);
    applyStimulus(1, 0, 1, 24'h123456, 6'h00);
    checkOutput("midrst d2", observed(), expOut(1, 0, 1, 1, 12'h014, 7'h19));
    applyStimulus(0, 0, 1, 24'h123456, 6'h00);
    checkOutput("midrst after", observed(), idle_exp);
    applyStimulus(0, 1, 1, 24'h123456, 6'h00);
    for (int d = 0; d < 6; d++) begin
      applyStimulus(0, 0, 1, 24'h123456, 6'h00);
      checkOutput($sformatf("midrst redo d%0d", d), observed(),
                  expOut(1, 0, 1, 1, 12'h00C + 12'(4 * d), exp123[d]));
    end
    applyStimulus(0, 0, 1, 24'h123456, 6'h00);
    checkOutput("midrst redo done", observed(), expOut(0, 1, 0, 0, 12'h000, 7'h00));

    // Polarity: both instances run the same update.
    applyStimulus(0, 1, 1, 24'h000008, 6'h00);
    for (int d = 0; d < 6; d++) begin
      applyStimulus(0, 0, 1, 24'h000008, 6'h00);
      checkOutput($sformatf("pol low d%0d", d), observed(),
                  expOut(1, 0, 1, 1, 12'h00C + 12'(4 * d), exp_pol_lo[d]));
      checkOutput($sformatf("pol high d%0d", d),
                  {hi_busy, hi_done, hi_bus_req, hi_CS, hi_WEN, hi_REN, hi_Addr, hi_DataOut},
                  expOut(1, 0, 1, 1, 12'h00C + 12'(4 * d), exp_pol_hi[d]));
    end
    applyStimulus(0, 0, 1, 24'h000008, 6'h00);
    checkOutput("pol high done",
                {hi_busy, hi_done, hi_bus_req, hi_CS, hi_WEN, hi_REN, hi_Addr, hi_DataOut},
                expOut(0, 1, 0, 0, 12'h000, 7'h00));

    // Back-to-back: start in FIN ignored, start in the next IDLE accepted.
    applyStimulus(0, 0, 1, 24'h000000, 6'h00);
    applyStimulus(0, 1, 1, 24'h123456, 6'h00);
    for (int d = 0; d < 6; d++) begin
      applyStimulus(0, 0, 1, 24'h123456, 6'h00);
    end
    applyStimulus(0, 1, 1, 24'hFFFFFF, 6'h00);
    checkOutput("b2b fin", observed(), expOut(0, 1, 0, 0, 12'h000, 7'h00));
    applyStimulus(0, 1, 1, 24'h00ABCD, 6'h00);
    checkOutput("b2b idle", observed(), idle_exp);
    applyStimulus(0, 0, 1, 24'hFFFFFF, 6'h3F);
    checkOutput("b2b d0", observed(), expOut(1, 0, 1, 1, 12'h00C, 7'h21));
    applyStimulus(0, 0, 1, 24'hFFFFFF, 6'h3F);
    checkOutput("b2b d1", observed(), expOut(1, 0, 1, 1, 12'h010, 7'h46));
    for (int d = 2; d < 6; d++) begin
      applyStimulus(0, 0, 1, 24'hFFFFFF, 6'h3F);
    end
    applyStimulus(0, 0, 1, 24'hFFFFFF, 6'h3F);
    checkOutput("b2b done", observed(), expOut(0, 1, 0, 0, 12'h000, 7'h00));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
